// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types and helpers for the (11,7) Hamming code.
package hamming_pkg;
  typedef logic [11:1] code_t;
  typedef logic [7:1] data_t;
  typedef logic [3:0] syndrome_t;
  localparam int SYN_MAX_CORR = 11;
  function automatic syndrome_t calc_syndrome(code_t z);
    return {z[8] ^ z[9] ^ z[10] ^ z[11],
            z[4] ^ z[5] ^ z[6] ^ z[7],
            z[2] ^ z[3] ^ z[6] ^ z[7] ^ z[10] ^ z[11],
            z[1] ^ z[3] ^ z[5] ^ z[7] ^ z[9] ^ z[11]};
  endfunction
  function automatic data_t extract_data(code_t z);
    return {z[11], z[10], z[9], z[7], z[6], z[5], z[3]};
  endfunction
endpackage

// File: rtl/hamming_err_counter.sv
// hamming_err_counter: saturating event counter with synchronous clear.
module hamming_err_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: 2-stage (11,7) Hamming decoder with valid/ready backpressure
// and saturating corrected/uncorrectable word counters.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  code_t            in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output syndrome_t        out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);
  logic      v1, v2, en1, en2, corr, unc;
  code_t     c1, fixed;
  syndrome_t s1;
  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v2;
  // syndrome equals the 1-based position of a single flipped bit
  always_comb begin
    corr  = s1 != '0 && s1 <= syndrome_t'(SYN_MAX_CORR);
    unc   = s1 > syndrome_t'(SYN_MAX_CORR);
    fixed = corr ? c1 ^ (code_t'(1) << (s1 - 1'b1)) : c1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      c1 <= '0;
      s1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      c1 <= in_code;
      s1 <= calc_syndrome(in_code);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2                <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (en2) begin
      v2                <= v1;
      out_data          <= extract_data(fixed);
      out_syndrome      <= s1;
      out_corrected     <= corr;
      out_uncorrectable <= unc;
    end
  hamming_err_counter #(.W(CNT_W)) u_corr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (v2 && out_ready && out_corrected),
    .cnt  (corr_cnt)
  );
  hamming_err_counter #(.W(CNT_W)) u_uncorr (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (v2 && out_ready && out_uncorrectable),
    .cnt  (uncorr_cnt)
  );
endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: vector table, handshake corner sequences and random
// traffic against a position-arithmetic reference model.
module tb_hamming_decoder;
  import hamming_pkg::*;
  typedef struct {
    data_t     d;
    syndrome_t s;
    logic      c;
    logic      u;
  } exp_t;
  typedef struct {
    code_t     code;
    data_t     d;
    syndrome_t s;
    logic      c;
    logic      u;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr_cnt = 0;
  code_t in_code = '0;
  logic in_ready, out_valid, out_corrected, out_uncorrectable;
  data_t out_data;
  syndrome_t out_syndrome;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic in_ready2, out_valid2, out_corrected2, out_uncorrectable2;
  data_t out_data2;
  syndrome_t out_syndrome2;
  logic [1:0] corr2, uncorr2;
  int checks = 0, errors = 0;
  int mc = 0, mu = 0, mc2 = 0, mu2 = 0;
  exp_t q[$];
  vec_t tbl[9];
  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable), .clr_cnt(clr_cnt),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );
  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_syndrome(out_syndrome2),
    .out_corrected(out_corrected2), .out_uncorrectable(out_uncorrectable2), .clr_cnt(clr_cnt),
    .corr_cnt(corr2), .uncorr_cnt(uncorr2)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int a, int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  // Reference: syndrome is the XOR of the indices of all set bits; data
  // lives at every non-power-of-two position, in ascending order.
  function automatic exp_t model(code_t z);
    exp_t e;
    int syn = 0, k = 1;
    code_t f = z;
    for (int i = 1; i <= 11; i++) if (z[i]) syn ^= i;
    e.s = syndrome_t'(syn);
    e.c = syn >= 1 && syn <= 11;
    e.u = syn >= 12;
    if (e.c) f[syn] = ~f[syn];
    e.d = '0;
    for (int i = 1; i <= 11; i++)
      if ((i & (i - 1)) != 0) begin
        e.d[k] = f[i];
        k++;
      end
    return e;
  endfunction
  function automatic code_t encode(data_t d);
    code_t z = '0;
    int syn = 0, k = 1;
    for (int i = 1; i <= 11; i++)
      if ((i & (i - 1)) != 0) begin
        z[i] = d[k];
        k++;
      end
    for (int i = 1; i <= 11; i++) if (z[i]) syn ^= i;
    z[1] = syn[0]; z[2] = syn[1]; z[4] = syn[2]; z[8] = syn[3];
    return z;
  endfunction
  function automatic code_t rand_code();
    code_t z = encode(data_t'($urandom));
    int r = $urandom_range(0, 3);
    int p = $urandom_range(1, 11);
    int p2 = (p % 11) + 1;
    if (r >= 1) z[p] = ~z[p];
    if (r == 3) z[p2] = ~z[p2];
    return z;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mc = 0; mu = 0; mc2 = 0; mu2 = 0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("mon_data", out_data, q[0].d);
          chk("mon_syn", out_syndrome, q[0].s);
          chk("mon_corr", out_corrected, q[0].c);
          chk("mon_unc", out_uncorrectable, q[0].u);
        end
      end
      if (out_valid2 && q.size() > 0) begin
        chk("mon2_data", out_data2, q[0].d);
        chk("mon2_syn", out_syndrome2, q[0].s);
        chk("mon2_flags", {out_corrected2, out_uncorrectable2}, {q[0].c, q[0].u});
      end
      chk("mon_corr_cnt", corr_cnt, mc);
      chk("mon_uncorr_cnt", uncorr_cnt, mu);
      chk("mon_corr_cnt2", corr2, mc2);
      chk("mon_uncorr_cnt2", uncorr2, mu2);
      if (clr_cnt) begin
        mc = 0; mu = 0; mc2 = 0; mu2 = 0;
      end else if (out_valid && out_ready && q.size() > 0) begin
        if (q[0].c) begin
          mc = mc < 65535 ? mc + 1 : mc;
          mc2 = mc2 < 3 ? mc2 + 1 : mc2;
        end
        if (q[0].u) begin
          mu = mu < 65535 ? mu + 1 : mu;
          mu2 = mu2 < 3 ? mu2 + 1 : mu2;
        end
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(in_code));
    end
  end
  task automatic send(code_t c);
    int n = 0;
    in_valid = 1;
    in_code = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    in_valid = 0;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic acc;
    tbl[0] = '{11'h54E, 7'h59, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{11'h56E, 7'h59, 4'd6, 1'b1, 1'b0};
    tbl[2] = '{11'h54F, 7'h59, 4'd1, 1'b1, 1'b0};
    tbl[3] = '{11'h5C6, 7'h59, 4'd12, 1'b0, 1'b1};
    tbl[4] = '{11'h14E, 7'h59, 4'd11, 1'b1, 1'b0};
    tbl[5] = '{11'h000, 7'h00, 4'd0, 1'b0, 1'b0};
    tbl[6] = '{11'h7FF, 7'h7F, 4'd0, 1'b0, 1'b0};
    tbl[7] = '{11'h200, 7'h00, 4'd10, 1'b1, 1'b0};
    tbl[8] = '{11'h10E, 7'h11, 4'd12, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready2", in_ready2, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_corrected, out_uncorrectable, out_syndrome}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].code);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, tbl[i].d);
      chk("tbl_syn", out_syndrome, tbl[i].s);
      chk("tbl_corr", out_corrected, tbl[i].c);
      chk("tbl_unc", out_uncorrectable, tbl[i].u);
      @(posedge clk);
      #1;
    end
    chk("tbl_corr_cnt", corr_cnt, 4);
    chk("tbl_uncorr_cnt", uncorr_cnt, 2);
    out_ready = 0;
    send(encode(7'h11));
    send(encode(7'h22));
    in_valid = 1;
    in_code = encode(7'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 7'h11);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(encode(7'h33));
    send(encode(7'h44));
    drain();
    @(posedge clk);
    #1 clr_cnt = 1;
    @(posedge clk);
    #1 clr_cnt = 0;
    for (int i = 0; i < 4; i++) send(encode(data_t'(i + 1)) ^ 11'h004);
    drain();
    chk("sat_corr2", corr2, 3);
    chk("sat_corr16", corr_cnt, 4);
    out_ready = 0;
    send(encode(7'h5A) ^ 11'h040);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("clr_pre_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1;
    clr_cnt = 1;
    @(posedge clk);
    #1 clr_cnt = 0;
    @(negedge clk);
    chk("clr_with_inc", corr_cnt, 0);
    chk("clr_with_inc2", corr2, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom % 4) != 0;
        in_code = rand_code();
      end
      out_ready = ($urandom % 4) != 0;
      clr_cnt = ($urandom % 60) == 0;
    end
    clr_cnt = 0;
    drain();
    out_ready = 0;
    send(encode(7'h2A) ^ 11'h002);
    send(encode(7'h15) ^ 11'h300);
    @(negedge clk);
    chk("mid_full", out_valid, 1);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_corr", corr_cnt, 0);
    chk("mid_rst_uncorr", uncorr_cnt, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_emit", out_valid, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
